cnn_weight_loader: RTL and testbench
====================================

Name: cnn_weight_loader

Overview:
- Sequencer in front of the CNN core: accepts a byte stream of weights over a valid/ready handshake, packs it into 16-byte chunks and drives the feature, fully-connected and bias memory write ports in order.
- After the load completes, starts the CNN with an active-low convolution_enable pulse and waits a fixed latency. It then latches cnn_output and pulses done.
- Also supports re-running the CNN on the already loaded weights with no reload.

Parameters:
- NUM_FEATURES, 3, feature kernels loaded.
- KERNEL_SIZE, 4, kernel side; one feature = KERNEL_SIZE*KERNEL_SIZE bytes = one chunk.
- FC_CHUNKS, 27, 16-byte fully-connected chunks (432 weights).
- DATA_WIDTH, 8, byte/weight width.
- CNN_LATENCY, 632, clk cycles from the convolution_enable pulse to cnn_output valid.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- load_start  in  1  active-high pulse; starts a full load and then a run.
- run_start  in  1  active-high pulse; runs the CNN with the current weights.
- din  in  8  weight byte (signed two's complement).
- din_valid  in  1  byte valid.
- din_ready  out  1  loader accepts a byte.
- chunk_data  out  128  packed chunk; byte k at [8k+7:8k], byte 0 = first received.
- feature_writeAddr  out  2  feature index.
- feature_WrEn  out  1  active-low feature write.
- fullyconnected_writeAddr  out  5  fully-connected chunk index.
- fullyconnected_WrEn  out  1  active-low fully-connected write.
- bias_data  out  32  NUM_FEATURES+1 bias bytes, byte 0 = first received.
- bias_WrEn  out  1  active-low bias write.
- convolution_enable  out  1  active-low CNN start.
- cnn_output  in  8  CNN result.
- result  out  8  latched result.
- done  out  1  one-cycle pulse when result is updated.
- busy  out  1  high in any state other than IDLE.
- error  out  1  checksum failure flag (0 when the optional feature is compiled out).

Behaviour:
- Reset (asynchronous, rst=0) sets the following; the same applies when reset is asserted mid-operation, with no partial write emitted:
  - state = IDLE.
  - All WrEn outputs and convolution_enable = 1.
  - din_ready = 0, done = 0, busy = 0, error = 0.
  - result = 0, chunk_data = 0, bias_data = 0, all addresses = 0.
  - Byte and chunk counters = 0.
- A byte transfers on a rising edge where din_valid and din_ready are both 1. din_ready is 1 only in the FEAT, FC, BIAS and CSUM states.
- States:
  - IDLE: load_start → FEAT. Else run_start → START. load_start wins if both are high. Inputs arriving in any other state are ignored.
  - FEAT: shift each byte into the chunk buffer. After the 16th byte → FWR.
  - FWR (1 cycle): feature_WrEn = 0, feature_writeAddr = chunk index, din_ready = 0. Then increment the chunk index. If the index was NUM_FEATURES-1 → FC (index cleared), else → FEAT.
  - FC / CWR: same pattern using fullyconnected_WrEn and fullyconnected_writeAddr 0..FC_CHUNKS-1. After the last chunk → BIAS.
  - BIAS: collect NUM_FEATURES+1 bytes into bias_data → BWR.
  - BWR (1 cycle): bias_WrEn = 0 → START (or CSUM when LOADER_CHECKSUM_EN is defined).
  - START (1 cycle): convolution_enable = 0, latency counter loaded with CNN_LATENCY-1 → WAIT.
  - WAIT: decrement the counter. At 0, result <= cnn_output, done = 1 for that cycle → IDLE.
- chunk_data and bias_data hold their values after the write; they are stable for the whole write cycle.
- Byte counter wraps 15→0 per chunk. The chunk counter never exceeds its limit.
- A full load is 48+432+4 = 484 bytes. Minimum load time is 484 + 31 write cycles.
- A stalled stream (din_valid=0) holds the current state indefinitely; there is no timeout.

Optional Feature:
- LOADER_CHECKSUM_EN.
- Defined:
  - After BWR the block enters CSUM and accepts one extra byte.
  - If that byte equals the mod-256 sum of all 484 weight bytes → START, error = 0.
  - On mismatch: error = 1, → IDLE with no CNN start. error stays set until the next load_start or reset.
- Undefined: no CSUM state, error tied to 0, BWR → START.

Test Plan:
- Reset mid-FC at chunk 10 → all WrEn = 1, busy = 0, din_ready = 0 within the reset cycle; the next load_start restarts at feature 0.
- load_start with bytes 0x00..0x0F, 0x10..0x1F, 0x20..0x2F for the features → feature_WrEn low for three single cycles with addr 0/1/2; chunk_data = 0x0F0E..0100 on the first write.
- Full load of 432 fully-connected bytes with valid toggling every other cycle → exactly 27 fullyconnected_WrEn pulses, addresses 0..26 in order, no byte lost.
- Bias bytes 0x01, 0xFF, 0x7F, 0x80 → bias_data = 0x807FFF01. convolution_enable is low exactly 1 cycle after the bias write; done rises CNN_LATENCY cycles later with result = cnn_output (drive 0x5A → result 0x5A).
- run_start in IDLE with no load → no WrEn pulses, the convolution_enable pulse follows the next cycle, done after 632 cycles. load_start and run_start asserted together → full load path taken.
- LOADER_CHECKSUM_EN defined: correct checksum → run proceeds. Checksum off by 1 → error = 1, convolution_enable stays 1, busy = 0.

Source files
------------

// File: rtl/cnn_weight_loader.sv
// Weight loader/sequencer for the CNN core: packs a byte stream into chunks, writes feature/FC/bias memories, then runs the core.
// Optional LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte that gates the run.
module cnn_weight_loader #(
  parameter int NUM_FEATURES = 3,
  parameter int KERNEL_SIZE  = 4,
  parameter int FC_CHUNKS    = 27,
  parameter int DATA_WIDTH   = 8,
  parameter int CNN_LATENCY  = 632
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          load_start,
  input  logic                                          run_start,
  input  logic signed [DATA_WIDTH-1:0]                  din,
  input  logic                                          din_valid,
  output logic                                          din_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] chunk_data,
  output logic [$clog2(NUM_FEATURES)-1:0]               feature_writeAddr,
  output logic                                          feature_WrEn,
  output logic [$clog2(FC_CHUNKS)-1:0]                  fullyconnected_writeAddr,
  output logic                                          fullyconnected_WrEn,
  output logic [(NUM_FEATURES+1)*DATA_WIDTH-1:0]        bias_data,
  output logic                                          bias_WrEn,
  output logic                                          convolution_enable,
  input  logic [DATA_WIDTH-1:0]                         cnn_output,
  output logic [DATA_WIDTH-1:0]                         result,
  output logic                                          done,
  output logic                                          busy,
  output logic                                          error
);

  localparam int CHUNK_BYTES = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CHUNK_W     = CHUNK_BYTES * DATA_WIDTH;
  localparam int BIAS_BYTES  = NUM_FEATURES + 1;
  localparam int BIAS_W      = BIAS_BYTES * DATA_WIDTH;
  localparam int FA_W        = $clog2(NUM_FEATURES);
  localparam int CA_W        = $clog2(FC_CHUNKS);
  localparam int CC_W        = (CA_W > FA_W) ? CA_W : FA_W;
  localparam int BC_W        = $clog2(CHUNK_BYTES);
  localparam int LAT_W       = $clog2(CNN_LATENCY);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FEAT  = 4'd1;
  localparam logic [3:0] S_FWR   = 4'd2;
  localparam logic [3:0] S_FC    = 4'd3;
  localparam logic [3:0] S_CWR   = 4'd4;
  localparam logic [3:0] S_BIAS  = 4'd5;
  localparam logic [3:0] S_BWR   = 4'd6;
  localparam logic [3:0] S_START = 4'd7;
  localparam logic [3:0] S_WAIT  = 4'd8;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CSUM  = 4'd9;
`endif

  logic [3:0]            state;
  logic [BC_W-1:0]       byte_cnt;
  logic [CC_W-1:0]       chunk_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [DATA_WIDTH-1:0] din_u;
  logic                  xfer;

  assign din_u = $unsigned(din);
  assign xfer  = din_valid & din_ready;

`ifdef LOADER_CHECKSUM_EN
  assign din_ready = (state == S_FEAT) || (state == S_FC) || (state == S_BIAS) || (state == S_CSUM);
`else
  assign din_ready = (state == S_FEAT) || (state == S_FC) || (state == S_BIAS);
`endif

  // Write strobes and the start pulse decode straight from state so reset releases them immediately.
  assign busy                     = (state != S_IDLE);
  assign feature_WrEn             = (state != S_FWR);
  assign fullyconnected_WrEn      = (state != S_CWR);
  assign bias_WrEn                = (state != S_BWR);
  assign convolution_enable       = (state != S_START);
  assign feature_writeAddr        = (state == S_FWR) ? chunk_cnt[FA_W-1:0] : '0;
  assign fullyconnected_writeAddr = (state == S_CWR) ? chunk_cnt[CA_W-1:0] : '0;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  // Running mod-256 sum over every weight byte; the trailing byte in CSUM is compared against it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum  <= '0;
      error <= 1'b0;
    end else begin
      if (state == S_IDLE && load_start) begin
        csum  <= '0;
        error <= 1'b0;
      end else if (xfer && state != S_CSUM) begin
        csum <= csum + din_u;
      end
      if (state == S_CSUM && xfer && din_u != csum)
        error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      chunk_cnt  <= '0;
      lat_cnt    <= '0;
      chunk_data <= '0;
      bias_data  <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            byte_cnt  <= '0;
            chunk_cnt <= '0;
            state     <= S_FEAT;
          end else if (run_start) begin
            state <= S_START;
          end
        end
        S_FEAT, S_FC: begin
          if (xfer) begin
            chunk_data <= {din_u, chunk_data[CHUNK_W-1:DATA_WIDTH]};
            if (byte_cnt == BC_W'(CHUNK_BYTES-1)) begin
              byte_cnt <= '0;
              state    <= (state == S_FEAT) ? S_FWR : S_CWR;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        S_FWR: begin
          if (chunk_cnt == CC_W'(NUM_FEATURES-1)) begin
            chunk_cnt <= '0;
            state     <= S_FC;
          end else begin
            chunk_cnt <= chunk_cnt + CC_W'(1);
            state     <= S_FEAT;
          end
        end
        S_CWR: begin
          if (chunk_cnt == CC_W'(FC_CHUNKS-1)) begin
            chunk_cnt <= '0;
            state     <= S_BIAS;
          end else begin
            chunk_cnt <= chunk_cnt + CC_W'(1);
            state     <= S_FC;
          end
        end
        S_BIAS: begin
          if (xfer) begin
            bias_data <= {din_u, bias_data[BIAS_W-1:DATA_WIDTH]};
            if (byte_cnt == BC_W'(BIAS_BYTES-1)) begin
              byte_cnt <= '0;
              state    <= S_BWR;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_BWR: state <= S_CSUM;
        S_CSUM: begin
          if (xfer)
            state <= (din_u == csum) ? S_START : S_IDLE;
        end
`else
        S_BWR: state <= S_START;
`endif
        S_START: begin
          lat_cnt <= LAT_W'(CNN_LATENCY-1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            result <= cnn_output;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Directed bench for cnn_weight_loader: load/run sequencing, memory write order, reset abort and optional checksum.
module tb_cnn_weight_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_start;
  logic         run_start;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_ready;
  logic [127:0] chunk_data;
  logic [1:0]   feature_writeAddr;
  logic         feature_WrEn;
  logic [4:0]   fullyconnected_writeAddr;
  logic         fullyconnected_WrEn;
  logic [31:0]  bias_data;
  logic         bias_WrEn;
  logic         convolution_enable;
  logic [7:0]   cnn_output;
  logic [7:0]   result;
  logic         done;
  logic         busy;
  logic         error;

  cnn_weight_loader dut (
    .clk                      (clk),
    .rst                      (rst),
    .load_start               (load_start),
    .run_start                (run_start),
    .din                      (din),
    .din_valid                (din_valid),
    .din_ready                (din_ready),
    .chunk_data               (chunk_data),
    .feature_writeAddr        (feature_writeAddr),
    .feature_WrEn             (feature_WrEn),
    .fullyconnected_writeAddr (fullyconnected_writeAddr),
    .fullyconnected_WrEn      (fullyconnected_WrEn),
    .bias_data                (bias_data),
    .bias_WrEn                (bias_WrEn),
    .convolution_enable       (convolution_enable),
    .cnn_output               (cnn_output),
    .result                   (result),
    .done                     (done),
    .busy                     (busy),
    .error                    (error)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] csum_model;

  logic [1:0]   f_addr_q[$];
  logic [127:0] f_data_q[$];
  logic [4:0]   c_addr_q[$];
  logic [127:0] c_data_q[$];
  int           b_cyc_q[$];
  logic [31:0]  b_data_q[$];
  int           ce_cyc_q[$];
  int           d_cyc_q[$];
  logic [7:0]   d_res_q[$];

  // Event log of every strobe, stamped with the falling-edge cycle number.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!feature_WrEn) begin
      f_addr_q.push_back(feature_writeAddr);
      f_data_q.push_back(chunk_data);
    end
    if (!fullyconnected_WrEn) begin
      c_addr_q.push_back(fullyconnected_writeAddr);
      c_data_q.push_back(chunk_data);
    end
    if (!bias_WrEn) begin
      b_cyc_q.push_back(cyc);
      b_data_q.push_back(bias_data);
    end
    if (!convolution_enable) ce_cyc_q.push_back(cyc);
    if (done) begin
      d_cyc_q.push_back(cyc);
      d_res_q.push_back(result);
    end
  end

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] fcb(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [127:0] fc_chunk(input int c);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = fcb(c * 16 + k);
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check_val("ready_timeout", 128'(t), 128'(0));
    tick();
    din_valid  = 1'b0;
    csum_model = csum_model + b;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) check_val("done_timeout", 128'(t), 128'(0));
  endtask

  task automatic start_load(input logic both);
    csum_model = 8'h00;
    load_start = 1'b1;
    run_start  = both;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
  endtask

  task automatic send_features();
    for (int i = 0; i < 48; i++) send_byte(8'(i));
  endtask

  task automatic send_fc(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_byte(fcb(i));
      if (gap) tick();
    end
  endtask

  task automatic send_bias();
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h7F);
    send_byte(8'h80);
  endtask

  task automatic send_csum(input logic [7:0] delta);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_model + delta);
`else
    if (delta != 8'h00) $display("note: checksum byte not used in this build");
`endif
  endtask

  task automatic check_load(input int fs, input int cs, input int bs, input int es, input int ds,
                            input logic [7:0] exp_res);
    int bad;
    check_val("feat_writes", 128'(f_addr_q.size() - fs), 128'(3));
    if (f_addr_q.size() - fs == 3) begin
      for (int j = 0; j < 3; j++) check_val("feat_addr", 128'(f_addr_q[fs+j]), 128'(j));
      check_val("feat0_data", f_data_q[fs], 128'h0f0e0d0c0b0a09080706050403020100);
      check_val("feat2_data", f_data_q[fs+2], 128'h2f2e2d2c2b2a29282726252423222120);
    end
    check_val("fc_writes", 128'(c_addr_q.size() - cs), 128'(27));
    bad = 0;
    for (int c = 0; c < 27; c++) begin
      if (cs + c < c_addr_q.size()) begin
        if (c_addr_q[cs+c] != 5'(c) || c_data_q[cs+c] != fc_chunk(c)) bad++;
      end
    end
    check_val("fc_order_data", 128'(bad), 128'(0));
    check_val("bias_writes", 128'(b_cyc_q.size() - bs), 128'(1));
    if (b_cyc_q.size() > bs) check_val("bias_data", 128'(b_data_q[bs]), 128'h807fff01);
    check_val("conv_pulses", 128'(ce_cyc_q.size() - es), 128'(1));
    check_val("done_pulses", 128'(d_cyc_q.size() - ds), 128'(1));
    if (ce_cyc_q.size() > es && b_cyc_q.size() > bs) begin
`ifndef LOADER_CHECKSUM_EN
      check_val("conv_after_bias", 128'(ce_cyc_q[es] - b_cyc_q[bs]), 128'(1));
`endif
    end
    // Enable pulse cycle, then CNN_LATENCY (632) cycles of counting before done is seen.
    if (ce_cyc_q.size() > es && d_cyc_q.size() > ds) begin
      check_val("done_latency", 128'(d_cyc_q[ds] - ce_cyc_q[es]), 128'(633));
      check_val("done_result", 128'(d_res_q[ds]), 128'(exp_res));
    end
  endtask

  int fs, cs, bs, es, ds, c0;

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    run_start  = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    cnn_output = 8'h5A;
    csum_model = 8'h00;
    tick();
    tick();

    check_val("rst_feat_wren", 128'(feature_WrEn), 128'(1));
    check_val("rst_fc_wren", 128'(fullyconnected_WrEn), 128'(1));
    check_val("rst_bias_wren", 128'(bias_WrEn), 128'(1));
    check_val("rst_conv_en", 128'(convolution_enable), 128'(1));
    check_val("rst_ready", 128'(din_ready), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_error", 128'(error), 128'(0));
    check_val("rst_result", 128'(result), 128'(0));
    check_val("rst_chunk", chunk_data, 128'(0));
    check_val("rst_bias", 128'(bias_data), 128'(0));
    check_val("rst_addrs", 128'({feature_writeAddr, fullyconnected_writeAddr}), 128'(0));
    rst = 1'b1;
    tick();

    // Full load with FC stream valid every other cycle.
    fs = f_addr_q.size(); cs = c_addr_q.size(); bs = b_cyc_q.size();
    es = ce_cyc_q.size(); ds = d_cyc_q.size();
    start_load(1'b0);
    send_features();
    send_fc(432, 1'b1);
    send_bias();
    send_csum(8'h00);
    wait_done();
    check_load(fs, cs, bs, es, ds, 8'h5A);
    tick();
    check_val("idle_busy", 128'(busy), 128'(0));
    check_val("held_result", 128'(result), 128'h5A);
    check_val("load_error", 128'(error), 128'(0));

    // Re-run on loaded weights: no memory writes, enable pulse the cycle after run_start.
    cnn_output = 8'hA5;
    fs = f_addr_q.size(); cs = c_addr_q.size(); bs = b_cyc_q.size();
    es = ce_cyc_q.size(); ds = d_cyc_q.size();
    c0 = cyc;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    wait_done();
    check_val("run_no_writes", 128'((f_addr_q.size() - fs) + (c_addr_q.size() - cs) + (b_cyc_q.size() - bs)), 128'(0));
    check_val("run_conv_pulses", 128'(ce_cyc_q.size() - es), 128'(1));
    if (ce_cyc_q.size() > es) begin
      check_val("run_conv_cycle", 128'(ce_cyc_q[es] - c0), 128'(1));
      if (d_cyc_q.size() > ds)
        check_val("run_latency", 128'(d_cyc_q[ds] - ce_cyc_q[es]), 128'(633));
    end
    check_val("run_result", 128'(result), 128'hA5);

    // Abort during the write of FC chunk 10, then reload with load_start and run_start together.
    start_load(1'b0);
    send_features();
    send_fc(176, 1'b0);
    check_val("abort_fc_wren", 128'(fullyconnected_WrEn), 128'(0));
    check_val("abort_fc_addr", 128'(fullyconnected_writeAddr), 128'(10));
    #2;
    rst = 1'b0;
    #1;
    check_val("abort_wrens", 128'({feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable}), 128'hF);
    check_val("abort_busy", 128'(busy), 128'(0));
    check_val("abort_ready", 128'(din_ready), 128'(0));
    tick();
    check_val("abort_chunk", chunk_data, 128'(0));
    check_val("abort_bias", 128'(bias_data), 128'(0));
    rst = 1'b1;
    tick();
    cnn_output = 8'h3C;
    fs = f_addr_q.size(); cs = c_addr_q.size(); bs = b_cyc_q.size();
    es = ce_cyc_q.size(); ds = d_cyc_q.size();
    start_load(1'b1);
    send_features();
    send_fc(432, 1'b0);
    send_bias();
    send_csum(8'h00);
    wait_done();
    check_load(fs, cs, bs, es, ds, 8'h3C);

`ifdef LOADER_CHECKSUM_EN
    // Checksum off by one: flag set, no CNN start, back to idle.
    es = ce_cyc_q.size(); ds = d_cyc_q.size();
    start_load(1'b0);
    send_features();
    send_fc(432, 1'b0);
    send_bias();
    send_csum(8'h01);
    tick();
    tick();
    check_val("csum_error", 128'(error), 128'(1));
    check_val("csum_busy", 128'(busy), 128'(0));
    check_val("csum_conv_en", 128'(convolution_enable), 128'(1));
    check_val("csum_no_start", 128'((ce_cyc_q.size() - es) + (d_cyc_q.size() - ds)), 128'(0));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_val("csum_error_clr", 128'(error), 128'(0));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
